// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side drain: state encoding,
// FIFO geometry and the byte-count helpers used to size the byte index.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    SEND = 2'd3
  } drainState_e;

  localparam int FIFO_WIDTH = 32;
  localparam int FIFO_DEPTH = 8;

  // Number of bytes carried by one FIFO word of the given width.
  function automatic int bytesPerWord(input int width);
    return width / 8;
  endfunction

  // Width of a byte index; a single-byte word still needs one bit.
  function automatic int idxWidth(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

  localparam int BYTES_PER_WORD = bytesPerWord(FIFO_WIDTH);

endpackage

// File: rtl/fifo_byte_drain_if.sv
// FIFO read port plus the byte-wide valid/ready stream. The master side is
// the drain controller; the slave side is the FIFO together with the consumer.
interface fifo_byte_drain_if #(
  parameter int WIDTH = 32
);

  logic             fifoEmpty;
  logic [WIDTH-1:0] fifoData;
  logic             fifoRd;
  logic [7:0]       byteData;
  logic             byteValid;
  logic             byteReady;

  modport master (
    input  fifoEmpty,
    input  fifoData,
    input  byteReady,
    output fifoRd,
    output byteData,
    output byteValid
  );

  modport slave (
    output fifoEmpty,
    output fifoData,
    output byteReady,
    input  fifoRd,
    input  byteData,
    input  byteValid
  );

endinterface

// File: rtl/byte_select.sv
// Combinational WIDTH-to-8 mux: picks the byte of a word addressed by idx,
// counting from the least or most significant end depending on LSB_FIRST.
module byte_select
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit LSB_FIRST = 1'b1,
  localparam int BYTES    = bytesPerWord(WIDTH),
  localparam int IDX_W    = idxWidth(BYTES)
) (
  input  logic [WIDTH-1:0] word,
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       byteOut
);

  // Walk every byte lane and forward the one whose position matches idx.
  always_comb begin
    byteOut = 8'h00;
    for (int i = 0; i < BYTES; i++) begin
      if (idx == IDX_W'(i)) begin
        if (LSB_FIRST) begin
          byteOut = word[8*i +: 8];
        end else begin
          byteOut = word[8*(BYTES-1-i) +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/fifo_byte_drain.sv
// Read-side controller for the word FIFO: pops one word at a time, absorbs
// the FIFO's one-cycle registered read latency and streams the word out as
// bytes on a valid/ready interface. Counts fully delivered words.
module fifo_byte_drain
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             EN,
  fifo_byte_drain_if.master bus,
  output logic             busy,
  output logic [CNT_W-1:0] wordCount
);

  localparam int BYTES = bytesPerWord(WIDTH);
  localparam int IDX_W = idxWidth(BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  drainState_e      state;
  drainState_e      stateNext;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idxNext;
  logic [WIDTH-1:0] wordReg;
  logic             wordLoad;
  logic             wordDone;
  logic             byteAccept;

  // The only handshake that matters is in SEND, where byteValid is always high.
  assign byteAccept = (state == SEND) && bus.byteReady;

  // Next-state logic; fifoEmpty is only looked at in IDLE and on the final
  // byte accept, so a flag that has not yet caught up with a pop is ignored.
  always_comb begin
    stateNext = state;
    idxNext   = idx;
    wordLoad  = 1'b0;
    wordDone  = 1'b0;
    case (state)
      IDLE: begin
        if (EN && !bus.fifoEmpty) begin
          stateNext = REQ;
        end
      end
      REQ: begin
        stateNext = WAIT;
      end
      WAIT: begin
        wordLoad  = 1'b1;
        idxNext   = '0;
        stateNext = SEND;
      end
      SEND: begin
        if (byteAccept) begin
          if (idx == LAST_IDX) begin
            wordDone  = 1'b1;
            idxNext   = '0;
            stateNext = (EN && !bus.fifoEmpty) ? REQ : IDLE;
          end else begin
            idxNext = idx + IDX_W'(1);
          end
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State and byte index register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= stateNext;
      idx   <= idxNext;
    end
  end

  // Registered strobes decoded from the next state so they line up with
  // REQ and SEND and never depend combinationally on byteReady.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      bus.fifoRd    <= 1'b0;
      bus.byteValid <= 1'b0;
    end else begin
      bus.fifoRd    <= (stateNext == REQ);
      bus.byteValid <= (stateNext == SEND);
    end
  end

  // Capture the FIFO output in WAIT, the cycle its registered data is valid.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wordReg <= '0;
    end else if (wordLoad) begin
      wordReg <= bus.fifoData;
    end
  end

  // Delivered-word counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wordCount <= '0;
    end else if (wordDone) begin
      wordCount <= wordCount + CNT_W'(1);
    end
  end

  assign busy = (state != IDLE);

  byte_select #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) byteMux (
    .word    (wordReg),
    .idx     (idx),
    .byteOut (bus.byteData)
  );

endmodule

// File: tb/tb_fifo_byte_drain.sv
// Directed bench for fifo_byte_drain: an LSB-first instance fed by a small
// 8-deep FIFO model, an MSB-first instance fed with a single word, and a
// 4-bit-counter instance fed by an always-non-empty source.
module tb_fifo_byte_drain;

  logic Clk = 1'b0;
  logic Rst;
  int   assertCount = 0;
  int   failCount   = 0;
  int   cycle       = 0;

  always #5 Clk = ~Clk;

  // Free-running cycle counter used to timestamp pops.
  always @(posedge Clk) cycle <= cycle + 1;

  // ---------------- LSB-first instance with FIFO model ----------------
  fifo_byte_drain_if #(.WIDTH(32)) lsbBus ();
  logic        lsbEn;
  logic        lsbReady;
  logic        lsbBusy;
  logic [15:0] lsbCount;

  fifo_byte_drain #(.WIDTH(32), .LSB_FIRST(1'b1), .CNT_W(16)) dutLsb (
    .Clk       (Clk),
    .Rst       (Rst),
    .EN        (lsbEn),
    .bus       (lsbBus),
    .busy      (lsbBusy),
    .wordCount (lsbCount)
  );

  logic [31:0] fifoMem [8];
  int          fifoWp = 0;
  int          fifoRp = 0;
  int          fifoCnt = 0;
  logic [31:0] fifoOut = '0;
  logic        pushEn;
  logic [31:0] pushData;
  logic        doPush;
  logic        doPop;

  assign doPush = pushEn && (fifoCnt < 8);
  assign doPop  = lsbBus.fifoRd && (fifoCnt > 0);

  // Behavioural FIFO with a registered read port, reset by the same Rst.
  always @(posedge Clk) begin
    if (Rst) begin
      fifoWp  <= 0;
      fifoRp  <= 0;
      fifoCnt <= 0;
      fifoOut <= '0;
    end else begin
      if (doPush) begin
        fifoMem[fifoWp] <= pushData;
        fifoWp <= (fifoWp + 1) % 8;
      end
      if (doPop) begin
        fifoOut <= fifoMem[fifoRp];
        fifoRp  <= (fifoRp + 1) % 8;
      end
      fifoCnt <= fifoCnt + (doPush ? 1 : 0) - (doPop ? 1 : 0);
    end
  end

  assign lsbBus.fifoEmpty = (fifoCnt == 0);
  assign lsbBus.fifoData  = fifoOut;
  assign lsbBus.byteReady = lsbReady;

  int         lsbRdCount = 0;
  int         lsbRdCycle[$];
  logic [7:0] lsbBytes[$];

  // Log pops and accepted bytes of the LSB instance.
  always @(posedge Clk) begin
    if (Rst) begin
      lsbRdCount <= 0;
      lsbRdCycle.delete();
      lsbBytes.delete();
    end else begin
      if (lsbBus.fifoRd) begin
        lsbRdCount <= lsbRdCount + 1;
        lsbRdCycle.push_back(cycle);
      end
      if (lsbBus.byteValid && lsbBus.byteReady) lsbBytes.push_back(lsbBus.byteData);
    end
  end

  // ---------------- MSB-first instance, single-word source ----------------
  fifo_byte_drain_if #(.WIDTH(32)) msbBus ();
  logic        msbEn;
  logic        msbEmpty;
  logic        msbReady;
  logic        msbBusy;
  logic [15:0] msbCount;
  int          msbRdCount = 0;

  fifo_byte_drain #(.WIDTH(32), .LSB_FIRST(1'b0), .CNT_W(16)) dutMsb (
    .Clk       (Clk),
    .Rst       (Rst),
    .EN        (msbEn),
    .bus       (msbBus),
    .busy      (msbBusy),
    .wordCount (msbCount)
  );

  assign msbBus.fifoEmpty = msbEmpty;
  assign msbBus.fifoData  = 32'h11223344;
  assign msbBus.byteReady = msbReady;

  // Count pops of the MSB instance.
  always @(posedge Clk) begin
    if (Rst) msbRdCount <= 0;
    else if (msbBus.fifoRd) msbRdCount <= msbRdCount + 1;
  end

  // ---------------- 4-bit counter instance, endless source ----------------
  fifo_byte_drain_if #(.WIDTH(32)) wrapBus ();
  logic       wrapEn;
  logic       wrapEmpty;
  logic       wrapBusy;
  logic [3:0] wrapCount;
  int         wrapRdCount = 0;

  fifo_byte_drain #(.WIDTH(32), .LSB_FIRST(1'b1), .CNT_W(4)) dutWrap (
    .Clk       (Clk),
    .Rst       (Rst),
    .EN        (wrapEn),
    .bus       (wrapBus),
    .busy      (wrapBusy),
    .wordCount (wrapCount)
  );

  assign wrapBus.fifoEmpty = wrapEmpty;
  assign wrapBus.fifoData  = 32'hCAFEF00D;
  assign wrapBus.byteReady = 1'b1;

  // Count pops of the wrap instance.
  always @(posedge Clk) begin
    if (Rst) wrapRdCount <= 0;
    else if (wrapBus.fifoRd) wrapRdCount <= wrapRdCount + 1;
  end

  // ---------------- helpers ----------------
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge Clk);
  endtask

  task automatic applyReset();
    Rst = 1'b1;
    tick(2);
    Rst = 1'b0;
    tick();
  endtask

  // Write one word into the FIFO model; returns in the cycle after the write.
  task automatic applyStimulus(input logic [31:0] word);
    pushEn   = 1'b1;
    pushData = word;
    tick();
    pushEn   = 1'b0;
  endtask

  // Safety net in case some wait loop is broken.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] exp1 [4];
    logic [7:0] exp2 [8];
    logic       pat2 [8];
    exp1 = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    exp2 = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h44, 8'h44, 8'h44};
    pat2 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    Rst = 1'b1; lsbEn = 1'b0; lsbReady = 1'b1; pushEn = 1'b0; pushData = '0;
    msbEn = 1'b0; msbEmpty = 1'b1; msbReady = 1'b0;
    wrapEn = 1'b0; wrapEmpty = 1'b0;
    tick(3);

    $display("[TB] reset state");
    checkOutput("rst_fifoRd", 32'(lsbBus.fifoRd), 0);
    checkOutput("rst_byteValid", 32'(lsbBus.byteValid), 0);
    checkOutput("rst_byteData", 32'(lsbBus.byteData), 0);
    checkOutput("rst_busy", 32'(lsbBusy), 0);
    checkOutput("rst_wordCount", 32'(lsbCount), 0);
    Rst = 1'b0;
    tick();

    $display("[TB] single word, LSB first");
    lsbEn = 1'b1;
    applyStimulus(32'hA1B2C3D4);
    checkOutput("t1_c0_fifoRd", 32'(lsbBus.fifoRd), 0);
    tick();
    checkOutput("t1_c1_fifoRd", 32'(lsbBus.fifoRd), 1);
    checkOutput("t1_c1_busy", 32'(lsbBusy), 1);
    tick();
    checkOutput("t1_c2_fifoRd", 32'(lsbBus.fifoRd), 0);
    checkOutput("t1_c2_valid", 32'(lsbBus.byteValid), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("t1_c%0d_valid", i + 3), 32'(lsbBus.byteValid), 1);
      checkOutput($sformatf("t1_c%0d_byte", i + 3), 32'(lsbBus.byteData), 32'(exp1[i]));
    end
    tick();
    checkOutput("t1_end_valid", 32'(lsbBus.byteValid), 0);
    checkOutput("t1_end_busy", 32'(lsbBusy), 0);
    checkOutput("t1_end_count", 32'(lsbCount), 1);
    checkOutput("t1_end_empty", 32'(lsbBus.fifoEmpty), 1);
    checkOutput("t1_end_rdCount", 32'(lsbRdCount), 1);

    $display("[TB] MSB first with backpressure");
    applyReset();
    msbEn = 1'b1;
    msbEmpty = 1'b0;
    tick();
    checkOutput("t2_c1_fifoRd", 32'(msbBus.fifoRd), 1);
    msbEmpty = 1'b1;
    tick();
    checkOutput("t2_c2_fifoRd", 32'(msbBus.fifoRd), 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput($sformatf("t2_c%0d_valid", i + 3), 32'(msbBus.byteValid), 1);
      checkOutput($sformatf("t2_c%0d_byte", i + 3), 32'(msbBus.byteData), 32'(exp2[i]));
      msbReady = pat2[i];
    end
    tick();
    checkOutput("t2_end_valid", 32'(msbBus.byteValid), 0);
    checkOutput("t2_end_busy", 32'(msbBusy), 0);
    checkOutput("t2_end_count", 32'(msbCount), 1);
    tick(5);
    checkOutput("t2_rdCount", 32'(msbRdCount), 1);
    msbReady = 1'b0;
    msbEn = 1'b0;

    $display("[TB] full drain of 8 words");
    applyReset();
    lsbEn = 1'b0;
    lsbReady = 1'b1;
    for (int k = 0; k < 8; k++) applyStimulus(32'(k));
    checkOutput("t3_full_empty", 32'(lsbBus.fifoEmpty), 0);
    checkOutput("t3_full_rdCount", 32'(lsbRdCount), 0);
    lsbEn = 1'b1;
    for (int g = 0; g < 200; g++) begin
      tick();
      if (lsbRdCount == 8 && !lsbBusy) break;
    end
    checkOutput("t3_idle", 32'(lsbBusy), 0);
    checkOutput("t3_rdCount", 32'(lsbRdCount), 8);
    for (int i = 1; i < lsbRdCycle.size(); i++)
      checkOutput($sformatf("t3_rdGap%0d", i), 32'(lsbRdCycle[i] - lsbRdCycle[i-1]), 6);
    checkOutput("t3_byteCount", 32'(lsbBytes.size()), 32);
    for (int i = 0; i < 32 && i < lsbBytes.size(); i++)
      checkOutput($sformatf("t3_byte%0d", i), 32'(lsbBytes[i]), (i % 4 == 0) ? 32'(i / 4) : 32'd0);
    checkOutput("t3_count", 32'(lsbCount), 8);
    checkOutput("t3_empty", 32'(lsbBus.fifoEmpty), 1);
    tick(10);
    checkOutput("t3_noExtraRd", 32'(lsbRdCount), 8);

    $display("[TB] EN gating");
    applyReset();
    lsbEn = 1'b0;
    applyStimulus(32'h0A0B0C0D);
    applyStimulus(32'h1A1B1C1D);
    applyStimulus(32'h2A2B2C2D);
    tick(10);
    checkOutput("t4_gated_rdCount", 32'(lsbRdCount), 0);
    checkOutput("t4_gated_busy", 32'(lsbBusy), 0);
    lsbEn = 1'b1;
    for (int g = 0; g < 50; g++) begin
      tick();
      if (lsbRdCount == 2 && lsbBus.byteValid) break;
    end
    checkOutput("t4_w2_byte1", 32'(lsbBus.byteData), 32'h1D);
    lsbEn = 1'b0;
    for (int g = 0; g < 50; g++) begin
      tick();
      if (!lsbBusy) break;
    end
    checkOutput("t4_idle", 32'(lsbBusy), 0);
    checkOutput("t4_count", 32'(lsbCount), 2);
    checkOutput("t4_leftover", 32'(fifoCnt), 1);
    tick(10);
    checkOutput("t4_rdCount", 32'(lsbRdCount), 2);

    $display("[TB] reset mid-word");
    applyReset();
    lsbEn = 1'b1;
    lsbReady = 1'b1;
    applyStimulus(32'hDEADBEEF);
    for (int g = 0; g < 20; g++) begin
      if (lsbBus.byteValid) break;
      tick();
    end
    checkOutput("t5_byte1", 32'(lsbBus.byteData), 32'hEF);
    tick();
    checkOutput("t5_byte2", 32'(lsbBus.byteData), 32'hBE);
    Rst = 1'b1;
    tick();
    checkOutput("t5_rst_valid", 32'(lsbBus.byteValid), 0);
    checkOutput("t5_rst_fifoRd", 32'(lsbBus.fifoRd), 0);
    checkOutput("t5_rst_count", 32'(lsbCount), 0);
    checkOutput("t5_rst_busy", 32'(lsbBusy), 0);
    checkOutput("t5_rst_byteData", 32'(lsbBus.byteData), 0);
    Rst = 1'b0;
    tick(10);
    checkOutput("t5_quiet_rdCount", 32'(lsbRdCount), 0);
    checkOutput("t5_quiet_valid", 32'(lsbBus.byteValid), 0);
    checkOutput("t5_quiet_busy", 32'(lsbBusy), 0);

    $display("[TB] counter wrap with 4-bit counter");
    applyReset();
    wrapEmpty = 1'b0;
    wrapEn = 1'b1;
    for (int g = 0; g < 300; g++) begin
      tick();
      if (wrapRdCount == 17) break;
    end
    wrapEn = 1'b0;
    for (int g = 0; g < 50; g++) begin
      tick();
      if (!wrapBusy) break;
    end
    checkOutput("t6_idle", 32'(wrapBusy), 0);
    checkOutput("t6_rdCount", 32'(wrapRdCount), 17);
    checkOutput("t6_count", 32'(wrapCount), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/fifo_byte_drain.md
# fifo_byte_drain

Read-side controller for the team's 32-bit, 8-deep synchronous FIFO. It pops words when the FIFO is not empty and serializes each word into bytes on a valid/ready byte stream. It sits between the FIFO's read port and a byte-wide consumer such as a UART TX or SPI shifter. It owns RD generation and absorbs the FIFO's one-cycle registered read latency.

## Interface
Parameters:
- WIDTH, 32, FIFO word width; must be a multiple of 8.
- LSB_FIRST, 1, 1 sends byte 0 (bits 7:0) first; 0 sends the MSB byte first.
- CNT_W, 16, width of the delivered-word counter.

Ports:
- Clk  in  1  single clock; all logic on the rising edge.
- Rst  in  1  reset; synchronous and active-high.
- EN  in  1  start enable; when low, no new pop starts and any word in flight completes.
- fifoEmpty  in  1  FIFO EMPTY flag.
- fifoData  in  WIDTH  FIFO dataOut.
- fifoRd  out  1  FIFO RD strobe; one-cycle pulse per word.
- byteData  out  8  current byte.
- byteValid  out  1  byteData is valid.
- byteReady  in  1  consumer accepts the byte when byteValid and byteReady are both high at a rising edge.
- busy  out  1  high in any state other than IDLE.
- wordCount  out  CNT_W  number of fully delivered words; wraps modulo 2^CNT_W.

## Operation
- The FSM has four states: IDLE, REQ, WAIT, SEND. The byte index `idx` ranges from 0 to WIDTH/8-1.
- IDLE: if EN=1 and fifoEmpty=0, go to REQ. Otherwise stay.
- REQ: fifoRd=1 for exactly this one cycle. Go to WAIT.
- WAIT: fifoData is valid this cycle. Latch it into the word register at the closing edge, set idx=0, go to SEND.
- SEND: byteValid=1. byteData is the word byte selected by idx, with order set by LSB_FIRST.
  - On an accepted byte with idx < last, increment idx.
  - On an accepted final byte, increment wordCount. Then go to REQ if EN=1 and fifoEmpty=0, else to IDLE.
- fifoRd is a registered decode of state REQ. It is never high for two consecutive cycles, so at most one pop per word.
- fifoEmpty is sampled only in IDLE and on the final-byte accept, never in REQ or WAIT. This prevents a double pop from a stale flag.
- fifoRd is never issued while fifoEmpty=1.
- Valid/ready rules:
  - byteValid must not depend combinationally on byteReady.
  - Once byteValid is raised, byteValid and byteData hold stable until accepted.
  - Backpressure of any length is legal.
- An EN drop during REQ, WAIT or SEND has no effect on the current word.
- The FIFO's own EN is tied high at integration. Its Rst is driven from the same Rst.

## Timing
- Reset values: state=IDLE, fifoRd=0, byteValid=0, byteData=0, idx=0, busy=0, wordCount=0.
- Reset mid-operation forces the reset values at the next edge. A partially sent word is discarded and not counted. The FIFO is reset by the same Rst, so no orphaned entries remain.
- Latency from a cycle with fifoEmpty=0 in IDLE (cycle 0):
  - fifoRd high in cycle 1.
  - Word latched at the end of cycle 2.
  - First byteValid in cycle 3.
- With byteReady held high, one WIDTH=32 word takes bytes in cycles 3–6.
- Back-to-back words: the next REQ is in cycle 7 and the next first byte in cycle 9. The steady-state period is 6 cycles per word.
- The final-byte accept and the next REQ decision use fifoEmpty from that same edge.
- wordCount updates at the edge of the final-byte accept. The new value is visible the following cycle. 0xFFFF+1 wraps to 0x0000.

## Structure
- Shared package fifo_pkg holds:
  - the state encoding constants (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, SEND=2'd3);
  - FIFO_WIDTH=32 and FIFO_DEPTH=8;
  - the BYTES_PER_WORD derivation.
- One natural sub-module is byte_select: a combinational WIDTH-to-8 mux driven by idx and LSB_FIRST.
- The word register, FSM and counter stay in fifo_byte_drain.
- Integration wrapper fifo_stream_top instantiates the FIFO with fifo_byte_drain.

## Test plan
- Single word, ready always high: write 0xA1B2C3D4, LSB_FIRST=1. Required: fifoRd one pulse; bytes D4, C3, B2, A1 in cycles 3–6; wordCount=1; FIFO EMPTY afterwards; busy drops.
- MSB order with backpressure: LSB_FIRST=0, word 0x11223344, byteReady toggling 1-0-0-1. Required: bytes 11, 22, 33, 44; byteData stable while byteValid=1 and byteReady=0; no extra fifoRd.
- Full drain: fill 8 words 0..7, ready high. Required: 8 fifoRd pulses, each separated by 6 cycles; 32 bytes in order; wordCount=8; no fifoRd after EMPTY rises.
- EN gating: EN=0 with 3 words queued gives no fifoRd. EN=1 starts the drain. EN dropped during byte 1 of word 2 lets word 2 finish, then the block goes to IDLE with 1 word left and wordCount=2.
- Reset mid-word: Rst during byte 2 of 0xDEADBEEF. Required: next cycle byteValid=0, fifoRd=0, wordCount=0, state IDLE; after release with FIFO empty, no activity.
- Counter wrap: CNT_W=4, deliver 17 words. Required: wordCount=1.
